// File: rtl/exp_inv_rom.sv
// rtl/exp_inv_rom.sv - inverse exponent: tn = round(td*ln(255/y)) via normalise, log LUT, multiply, round/saturate
module exp_inv_rom #(
  parameter int wTn = 6,
  parameter int wTd = 6,
  parameter int wY  = 8,
  parameter int wF  = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           req,
  input  logic [wY-1:0]  y,
  input  logic [wTd-1:0] td,
  output logic           busy,
  output logic           valid,
  output logic [wTn-1:0] tn
);

  localparam int LUT_N = 2 ** (wY - 1);
  localparam int FS    = 2 ** wY - 1;
  localparam int LW    = wF + 3;
  localparam int PW    = LW + wTd;
  localparam int EW    = wF + 1;
  localparam logic [LW-1:0]  LN2    = LW'(710);
  localparam logic [PW-1:0]  HALF   = PW'(2 ** (wF - 1));
  localparam logic [wTn-1:0] TN_MAX = '1;

  typedef enum logic [2:0] {IDLE, NORM, LOOK, MUL, OUT} state_t;

  // Elaboration-time table: round(2^wF * ln(FS/n)) via 2*atanh((FS-n)/(FS+n)) in Q.30.
  function automatic logic [wF:0] lut_entry(input int idx);
    logic [63:0] n, z, z2, term, sum, k;
    n    = 64'(idx) + 64'(LUT_N);
    z    = ((64'(FS) - n) << 30) / (64'(FS) + n);
    z2   = (z * z) >> 30;
    term = z;
    sum  = '0;
    for (k = 64'd1; k < 64'd41; k = k + 64'd2) begin
      sum  = sum + term / k;
      term = (term * z2) >> 30;
    end
    lut_entry = EW'(((sum << (wF + 1)) + (64'd1 << 29)) >> 30);
  endfunction

  logic [wF:0] log_lut [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [wF:0] ENTRY = lut_entry(g);
    assign log_lut[g] = ENTRY;
  end

  state_t         state, state_n;
  logic [wY-1:0]  m;
  logic [2:0]     s;
  logic [wTd-1:0] td_r;
  logic           sat;
  logic [LW-1:0]  l_r;
  logic [PW-1:0]  p_r;
  logic [PW-1:0]  rnd;
  logic [wTn-1:0] tn_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req) state_n = (y == '0) ? MUL : NORM;
      NORM: if (m[wY-1]) state_n = LOOK;
      LOOK: state_n = MUL;
      MUL:  state_n = OUT;
      OUT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rnd  = (p_r + HALF) >> wF;
    tn_n = '0;
    if (sat || rnd > PW'(TN_MAX)) tn_n = TN_MAX;
    else                          tn_n = rnd[wTn-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      tn    <= '0;
      m     <= '0;
      s     <= '0;
      td_r  <= '0;
      sat   <= 1'b0;
      l_r   <= '0;
      p_r   <= '0;
    end else begin
      state <= state_n;
      valid <= 1'b0;
      case (state)
        IDLE: if (req) begin
          m    <= y;
          td_r <= td;
          s    <= '0;
          sat  <= (y == '0);
          busy <= 1'b1;
        end
        NORM: if (!m[wY-1]) begin
          m <= m << 1;
          s <= s + 3'd1;
        end
        LOOK: l_r <= LW'(log_lut[m[wY-2:0]]) + LW'(s) * LN2;
        MUL:  p_r <= PW'(l_r) * PW'(td_r);
        OUT: begin
          tn    <= tn_n;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_inv_rom.sv
// tb/tb_exp_inv_rom.sv - self-checking bench for exp_inv_rom
module tb_exp_inv_rom;
  localparam int wTn = 6, wTd = 6, wY = 8, wF = 10;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           req = 1'b0;
  logic [wY-1:0]  y = '0;
  logic [wTd-1:0] td = '0;
  logic           busy, valid;
  logic [wTn-1:0] tn;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exp_inv_rom #(.wTn(wTn), .wTd(wTd), .wY(wY), .wF(wF)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .y(y), .td(td),
    .busy(busy), .valid(valid), .tn(tn)
  );

  typedef struct {
    int y;
    int td;
    int tn;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_shift(input int yy);
    int s = 0;
    int v = yy;
    while (v < 128) begin
      v = v * 2;
      s++;
    end
    return s;
  endfunction

  function automatic int ref_tn(input int yy, input int tdd);
    int s, m, l, q;
    real lr;
    if (yy == 0) return 63;
    s  = ref_shift(yy);
    m  = yy << s;
    lr = 1024.0 * $ln(255.0 / real'(m));
    l  = $rtoi(lr + 0.5) + s * 710;
    q  = (l * tdd + 512) / 1024;
    return (q > 63) ? 63 : q;
  endfunction

  function automatic int ref_lat(input int yy);
    return (yy == 0) ? 2 : ref_shift(yy) + 4;
  endfunction

  // Issues one request and waits for valid; lat counts edges after the accepting edge.
  task automatic do_req(input int yy, input int tdd, input bit now,
                        output int got_tn, output int lat, output bit busy_ok);
    if (!now) @(negedge clk);
    y = yy[wY-1:0];
    td = tdd[wTd-1:0];
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1;
    got_tn = -1;
    busy_ok = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (valid) begin
        lat = j;
        got_tn = int'(tn);
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
    end
  endtask

  vec_t vecs[8];
  int   got_tn, lat, nval;
  bit   bok;

  initial begin
    vecs[0] = '{255, 10, 0, 4};
    vecs[1] = '{128, 63, 43, 4};
    vecs[2] = '{93, 20, 20, 5};
    vecs[3] = '{1, 8, 44, 11};
    vecs[4] = '{1, 63, 63, 11};
    vecs[5] = '{0, 5, 63, 2};
    vecs[6] = '{200, 0, 0, 4};
    vecs[7] = '{0, 0, 63, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_tn", 32'(tn), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].y, vecs[i].td, 1'b0, got_tn, lat, bok);
      check($sformatf("vec%0d_tn", i), 32'(got_tn), 32'(vecs[i].tn));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(bok), 1);
    end

    // Second request held while busy must be ignored.
    @(negedge clk);
    y = 8'd1; td = 6'd8; req = 1'b1;
    @(posedge clk);
    #1 y = 8'd255; td = 6'd10;
    nval = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (j == 5) req = 1'b0;
      if (valid) begin
        nval++;
        check("ignored_tn", 32'(tn), 44);
      end
    end
    check("ignored_count", 32'(nval), 1);

    // Reset during NORM aborts with no valid.
    @(negedge clk);
    y = 8'd1; td = 6'd8; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_tn", 32'(tn), 0);
    reset_n = 1'b1;
    nval = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    check("abort_no_valid", 32'(nval), 0);
    do_req(255, 10, 1'b0, got_tn, lat, bok);
    check("after_abort_tn", 32'(got_tn), 0);
    check("after_abort_lat", 32'(lat), 4);

    // Request accepted in the cycle valid is high.
    do_req(93, 20, 1'b0, got_tn, lat, bok);
    check("b2b_first_tn", 32'(got_tn), 20);
    do_req(128, 63, 1'b1, got_tn, lat, bok);
    check("b2b_second_tn", 32'(got_tn), 43);
    check("b2b_second_lat", 32'(lat), 4);

    for (int i = 0; i < 40; i++) begin
      int yy, tdd;
      yy  = (i % 5 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
      tdd = int'($urandom_range(0, 63));
      do_req(yy, tdd, 1'b0, got_tn, lat, bok);
      check($sformatf("rnd%0d_tn(y=%0d,td=%0d)", i, yy, tdd), 32'(got_tn), 32'(ref_tn(yy, tdd)));
      check($sformatf("rnd%0d_lat(y=%0d)", i, yy), 32'(lat), 32'(ref_lat(yy)));
      check($sformatf("rnd%0d_busy", i), 32'(bok), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
